// File: rtl/scroll_column_scheduler.sv
// Two-channel peak-decimating column scheduler for a scrolling display.
// Each channel reduces a window of accepted samples to its unsigned peak,
// parks the result in a hold register and raises a pending flag. A shared
// arbiter emits one column per cycle to the downstream buffers.
module scroll_column_scheduler #(
  parameter int DATA_W  = 12,
  parameter int DECIM_W = 8
) (
  input  logic               data_clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in_data_a,
  input  logic               in_valid_a,
  input  logic [DATA_W-1:0]  in_data_b,
  input  logic               in_valid_b,
  input  logic [DECIM_W-1:0] decim,
  input  logic               pause,
  input  logic               clear_overrun,
  output logic [DATA_W-1:0]  sink_data_a,
  output logic               sink_valid_a,
  output logic [DATA_W-1:0]  sink_data_b,
  output logic               sink_valid_b,
  output logic               overrun_a,
  output logic               overrun_b
);

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

  // Channel index 0 is A, 1 is B.
  localparam int NCH = 2;

  logic [DATA_W-1:0]  in_data   [NCH];
  logic               in_valid  [NCH];

  logic [DATA_W-1:0]  peak_q    [NCH];
  logic [DATA_W-1:0]  peak_d    [NCH];
  logic [DECIM_W-1:0] cnt_q     [NCH];
  logic [DECIM_W-1:0] cnt_d     [NCH];
  logic [DECIM_W-1:0] len_q     [NCH];
  logic [DECIM_W-1:0] len_d     [NCH];
  logic [DATA_W-1:0]  hold_q    [NCH];
  logic [DATA_W-1:0]  hold_d    [NCH];
  logic               pend_q    [NCH];
  logic               pend_d    [NCH];
  logic               ovr_q     [NCH];
  logic               ovr_d     [NCH];
  logic               grant     [NCH];

  logic [DATA_W-1:0]  sink_data_q [NCH];
  logic [DATA_W-1:0]  sink_data_d [NCH];

  state_t state_q, state_d;
  // Set when the most recent contended grant went to A; cleared (B) after
  // reset so that A wins the first contention.
  logic   last_a_q, last_a_d;

  assign in_data[0]  = in_data_a;
  assign in_data[1]  = in_data_b;
  assign in_valid[0] = in_valid_a;
  assign in_valid[1] = in_valid_b;

  // Window accumulation, column capture, pending and overrun next-state.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      logic               accept;
      logic               first;
      logic [DECIM_W-1:0] eff_len;
      logic [DATA_W-1:0]  new_peak;
      logic [DECIM_W-1:0] cnt_inc;
      logic               done;

      // NOTE: every combinational output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      peak_d[ch] = peak_q[ch];
      cnt_d[ch]  = cnt_q[ch];
      len_d[ch]  = len_q[ch];
      hold_d[ch] = hold_q[ch];

      accept   = in_valid[ch] && !pause;
      first    = (cnt_q[ch] == '0);
      eff_len  = first ? ((decim == '0) ? DECIM_W'(1) : decim) : len_q[ch];
      new_peak = (first || in_data[ch] > peak_q[ch]) ? in_data[ch] : peak_q[ch];
      cnt_inc  = cnt_q[ch] + DECIM_W'(1);
      done     = accept && (cnt_inc == eff_len);

      if (accept) begin
        peak_d[ch] = new_peak;
        len_d[ch]  = eff_len;
        cnt_d[ch]  = done ? '0 : cnt_inc;
        if (done) hold_d[ch] = new_peak;
      end

      // A completion on the grant edge re-arms pending without an overrun.
      pend_d[ch] = done || (pend_q[ch] && !grant[ch]);
      // Set wins over a concurrent clear.
      ovr_d[ch]  = (done && pend_q[ch] && !grant[ch]) ||
                   (ovr_q[ch] && !clear_overrun);

      sink_data_d[ch] = grant[ch] ? hold_q[ch] : sink_data_q[ch];
    end
  end

  // Per-channel state registers with synchronous reset.
  always_ff @(posedge data_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    for (int ch = 0; ch < NCH; ch++) begin
      if (!reset_n) begin
        peak_q[ch]      <= '0;
        cnt_q[ch]       <= '0;
        len_q[ch]       <= '0;
        hold_q[ch]      <= '0;
        pend_q[ch]      <= 1'b0;
        ovr_q[ch]       <= 1'b0;
        sink_data_q[ch] <= '0;
      end else begin
        peak_q[ch]      <= peak_d[ch];
        cnt_q[ch]       <= cnt_d[ch];
        len_q[ch]       <= len_d[ch];
        hold_q[ch]      <= hold_d[ch];
        pend_q[ch]      <= pend_d[ch];
        ovr_q[ch]       <= ovr_d[ch];
        sink_data_q[ch] <= sink_data_d[ch];
      end
    end
  end

  // Arbiter state register and round-robin memory.
  always_ff @(posedge data_clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_a_q <= last_a_d;
    end
  end

  // Arbiter next state: each EMIT lasts one cycle, then re-arbitrates.
  // Round robin only tracks contended grants, so successive contentions
  // alternate their winner even when uncontended grants occur in between.
  always_comb begin
    state_d  = IDLE;
    last_a_d = last_a_q;
    if (pend_q[0] && pend_q[1]) begin
      state_d  = last_a_q ? EMIT_B : EMIT_A;
      last_a_d = !last_a_q;
    end else if (pend_q[0]) begin
      state_d = EMIT_A;
    end else if (pend_q[1]) begin
      state_d = EMIT_B;
    end
    grant[0] = (state_d == EMIT_A);
    grant[1] = (state_d == EMIT_B);
  end

  // Arbiter outputs: write strobes decoded from the registered state.
  always_comb begin
    sink_valid_a = (state_q == EMIT_A);
    sink_valid_b = (state_q == EMIT_B);
  end

  assign sink_data_a = sink_data_q[0];
  assign sink_data_b = sink_data_q[1];
  assign overrun_a   = ovr_q[0];
  assign overrun_b   = ovr_q[1];

endmodule
